pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipelined RV32I core. It drives stall/flush enables on the IF/ID, ID/EX, EX/MA and MA/WB pipeline registers, selects EX-stage operand forwarding, and holds the MA stage with a req/ack handshake while a variable-latency data memory completes. It also keeps saturating hazard performance counters and flags a memory timeout. Outputs are combinational from the current inputs and FSM state; the FSM and counters are registered.

## Interface
- CNT_W, 32: width of each performance counter
- TIMEOUT, 255: maximum BUSY cycles without dm_ack before the error state; range 1..1023
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- D_rs1, D_rs2  in  5 each  source registers of the instruction in ID
- E_rs1, E_rs2  in  5 each  source registers of the instruction in EX
- E_rd  in  5  destination register in EX
- E_we_rf  in  1  EX instruction writes the register file
- E_sel_result  in  2  EX result select; 00 ALU, 01 data memory (load), 10 PC+4, 11 immediate (LUI)
- E_branch_taken  in  1  branch/jump resolved taken in EX
- M_rd  in  5  destination register in MA
- M_we_rf, M_we_dm  in  1 each  MA register-file write enable and store enable
- M_sel_result  in  2  MA result select, same encoding
- W_rd  in  5  destination register in WB
- W_we_rf  in  1  WB register-file write enable
- dm_ack  in  1  data memory has completed the access this cycle
- cnt_clr  in  1  synchronous clear of all counters
- dm_req  out  1  data memory access request
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold PC, IF/ID, ID/EX, EX/MA
- flush_D, flush_E, flush_W  out  1 each  synchronously zero IF/ID, ID/EX, MA/WB
- pc_redirect  out  1  PC loads the branch target
- fwd_a, fwd_b  out  2 each  EX operand source; 00 register file, 10 MA result, 01 WB result
- mem_err  out  1  sticky memory timeout flag
- cnt_mem_stall, cnt_lu_stall, cnt_flush  out  CNT_W each  performance counters

## Operation
- M_mem_op = M_we_dm | (M_sel_result == 01).
- FSM states: IDLE, BUSY, ERROR.
  - IDLE: dm_req = M_mem_op. If M_mem_op & !dm_ack, move to BUSY and clear the wait counter. If dm_ack arrives in the same cycle, the access is zero-wait and no stall occurs.
  - BUSY: dm_req = 1. On dm_ack, return to IDLE. If the wait counter reaches TIMEOUT without dm_ack, move to ERROR.
  - ERROR: dm_req = 0, mem_err = 1. Stays here until rst.
- mem_stall = (IDLE & M_mem_op & !dm_ack) | (BUSY & !dm_ack) | ERROR.
- load_use = E_we_rf & (E_sel_result == 01) & (E_rd != 0) & (E_rd == D_rs1 | E_rd == D_rs2).
- Priority, highest first:
  - mem_stall: stall_F, stall_D, stall_E and stall_M all 1; flush_W = 1; flush_D, flush_E and pc_redirect all 0.
  - E_branch_taken: pc_redirect, flush_D and flush_E all 1; no stalls. A simultaneous load_use is ignored because the ID instruction is wrong-path.
  - load_use: stall_F, stall_D and flush_E all 1.
  - Otherwise all control outputs are 0.
- Forwarding for fwd_a (from E_rs1) and fwd_b (from E_rs2):
  - 10 if rs != 0 & M_we_rf & M_rd == rs.
  - Else 01 if rs != 0 & W_we_rf & W_rd == rs.
  - Else 00.
  - MA has priority over WB.
- Counters are registered and saturate at all-ones. Each increments by 1 per cycle in which its qualifier is true and the pipeline is not in ERROR:
  - cnt_mem_stall: mem_stall.
  - cnt_lu_stall: load_use while not mem_stall and not E_branch_taken.
  - cnt_flush: pc_redirect.
- cnt_clr zeroes all counters and takes precedence over increment. It does not affect the FSM or mem_err.

## Timing
- Reset values: FSM = IDLE, wait counter = 0, mem_err = 0, all counters = 0. With all inputs 0, every output is 0.
- All control and forward outputs are combinational, with zero latency from their inputs.
- Handshake: once dm_req rises it stays high until the cycle in which dm_ack = 1. The EX/MA contents stay stable meanwhile because stall_M is held.
- On the dm_ack cycle stall_M = 0, so the pipeline advances on the next edge. dm_ack while dm_req = 0 is ignored.
- The wait counter increments each BUSY cycle. ERROR is entered on the edge after TIMEOUT BUSY cycles without an ack.
- rst asserted mid-BUSY returns the FSM to IDLE immediately; dm_req drops combinationally.
- Counter values update on the edge following their qualifying cycle.

## Test plan
- Forwarding: E_rs1 = 5, M_rd = 5, M_we_rf = 1, W_rd = 5, W_we_rf = 1 -> fwd_a = 10. Then M_we_rf = 0 -> fwd_a = 01. Then E_rs1 = 0 -> fwd_a = 00.
- Load-use: E_sel_result = 01, E_we_rf = 1, E_rd = 7, D_rs2 = 7 -> stall_F = stall_D = flush_E = 1 for one cycle; cnt_lu_stall reads 1 afterwards.
- Branch with concurrent load-use: E_branch_taken = 1 plus load_use -> pc_redirect = flush_D = flush_E = 1, stall_F = 0; cnt_flush increments and cnt_lu_stall does not.
- Memory wait: M_we_dm = 1, dm_ack held low for 3 cycles then high -> dm_req high for 4 cycles, stall_M and flush_W high for 3 cycles, stall_M = 0 on the ack cycle; cnt_mem_stall = 3.
- Timeout (TIMEOUT = 4): load in MA with dm_ack = 0 -> ERROR after 4 BUSY cycles; mem_err = 1, dm_req = 0, stalls held. rst -> IDLE, mem_err = 0.
- Saturation and clear (CNT_W = 4): 20 memory stall cycles -> cnt_mem_stall = 15. cnt_clr = 1 -> 0 on the next edge, even with a stall pending.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: register
// identifiers and write enables from ID/EX/MA/WB, the data-memory
// req/ack pair, and the stall/flush/forward controls plus counters.
//
// dm_req/dm_ack handshake: the controller raises dm_req while the MA
// instruction is a memory op; once up it stays up until a cycle in which
// dm_ack = 1, and that cycle completes the access. dm_ack seen while
// dm_req = 0 has no effect.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_rs1;
  logic [4:0]       D_rs2;
  logic [4:0]       E_rs1;
  logic [4:0]       E_rs2;
  logic [4:0]       E_rd;
  logic             E_we_rf;
  logic [1:0]       E_sel_result;
  logic             E_branch_taken;
  logic [4:0]       M_rd;
  logic             M_we_rf;
  logic             M_we_dm;
  logic [1:0]       M_sel_result;
  logic [4:0]       W_rd;
  logic             W_we_rf;
  logic             dm_ack;
  logic             cnt_clr;

  logic             dm_req;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             flush_D;
  logic             flush_E;
  logic             flush_W;
  logic             pc_redirect;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] cnt_mem_stall;
  logic [CNT_W-1:0] cnt_lu_stall;
  logic [CNT_W-1:0] cnt_flush;

  // Controller side.
  modport master (
    input  D_rs1, D_rs2, E_rs1, E_rs2, E_rd, E_we_rf, E_sel_result,
           E_branch_taken, M_rd, M_we_rf, M_we_dm, M_sel_result,
           W_rd, W_we_rf, dm_ack, cnt_clr,
    output dm_req, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, pc_redirect, fwd_a, fwd_b,
           mem_err, cnt_mem_stall, cnt_lu_stall, cnt_flush
  );

  // Datapath / memory side.
  modport slave (
    output D_rs1, D_rs2, E_rs1, E_rs2, E_rd, E_we_rf, E_sel_result,
           E_branch_taken, M_rd, M_we_rf, M_we_dm, M_sel_result,
           W_rd, W_we_rf, dm_ack, cnt_clr,
    input  dm_req, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, pc_redirect, fwd_a, fwd_b,
           mem_err, cnt_mem_stall, cnt_lu_stall, cnt_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Stall/flush/forward controls are combinational from the current inputs
// and memory FSM state; the FSM, wait counter, error flag and saturating
// performance counters are registered. state_dbg exposes the FSM state.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_ctrl_if.master       bus,
  output logic [1:0]                   state_dbg
);

  localparam int WAIT_W = 10;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic              mem_op;
  logic              mem_stall;
  logic              load_use;

  logic [CNT_W-1:0]  cnt_mem_q, cnt_lu_q, cnt_flush_q;

  assign mem_op   = bus.M_we_dm | (bus.M_sel_result == 2'b01);
  assign load_use = bus.E_we_rf & (bus.E_sel_result == 2'b01) &
                    (bus.E_rd != 5'd0) &
                    ((bus.E_rd == bus.D_rs1) | (bus.E_rd == bus.D_rs2));

  assign state_dbg = state;

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Memory-access FSM: next state, wait count, dm_req and the memory stall.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus.dm_req   = 1'b0;
    mem_stall    = 1'b0;
    case (state)
      IDLE: begin
        bus.dm_req = mem_op;
        // A same-cycle ack is a zero-wait access and never stalls.
        if (mem_op && !bus.dm_ack) begin
          mem_stall    = 1'b1;
          state_nxt    = BUSY;
          wait_cnt_nxt = '0;
        end
      end
      BUSY: begin
        bus.dm_req = 1'b1;
        if (bus.dm_ack) begin
          state_nxt = IDLE;
        end else begin
          mem_stall = 1'b1;
          // This is the TIMEOUT-th busy cycle without an ack.
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      ERROR: begin
        // Terminal until reset; the pipeline stays frozen.
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_err = (state == ERROR);

  // Prioritised stall/flush/redirect: memory wait, then taken branch
  // (the ID instruction is wrong-path so a load-use there is moot),
  // then load-use.
  always_comb begin
    bus.stall_F     = 1'b0;
    bus.stall_D     = 1'b0;
    bus.stall_E     = 1'b0;
    bus.stall_M     = 1'b0;
    bus.flush_D     = 1'b0;
    bus.flush_E     = 1'b0;
    bus.flush_W     = 1'b0;
    bus.pc_redirect = 1'b0;
    if (mem_stall) begin
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.stall_E = 1'b1;
      bus.stall_M = 1'b1;
      bus.flush_W = 1'b1;
    end else if (bus.E_branch_taken) begin
      bus.pc_redirect = 1'b1;
      bus.flush_D     = 1'b1;
      bus.flush_E     = 1'b1;
    end else if (load_use) begin
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.flush_E = 1'b1;
    end
  end

  // EX operand forwarding; the younger MA result wins over WB.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (bus.E_rs1 != 5'd0 && bus.M_we_rf && bus.M_rd == bus.E_rs1) begin
      bus.fwd_a = 2'b10;
    end else if (bus.E_rs1 != 5'd0 && bus.W_we_rf && bus.W_rd == bus.E_rs1) begin
      bus.fwd_a = 2'b01;
    end
    if (bus.E_rs2 != 5'd0 && bus.M_we_rf && bus.M_rd == bus.E_rs2) begin
      bus.fwd_b = 2'b10;
    end else if (bus.E_rs2 != 5'd0 && bus.W_we_rf && bus.W_rd == bus.E_rs2) begin
      bus.fwd_b = 2'b01;
    end
  end

  // Saturating performance counters; frozen in ERROR, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_mem_q   <= '0;
      cnt_lu_q    <= '0;
      cnt_flush_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_mem_q   <= '0;
      cnt_lu_q    <= '0;
      cnt_flush_q <= '0;
    end else if (state != ERROR) begin
      if (mem_stall && cnt_mem_q != '1) begin
        cnt_mem_q <= cnt_mem_q + 1'b1;
      end
      if (load_use && !mem_stall && !bus.E_branch_taken && cnt_lu_q != '1) begin
        cnt_lu_q <= cnt_lu_q + 1'b1;
      end
      if (bus.pc_redirect && cnt_flush_q != '1) begin
        cnt_flush_q <= cnt_flush_q + 1'b1;
      end
    end
  end

  assign bus.cnt_mem_stall = cnt_mem_q;
  assign bus.cnt_lu_stall  = cnt_lu_q;
  assign bus.cnt_flush     = cnt_flush_q;

endmodule
